// File: rtl/icewerx_adc_filter.sv
// icewerx_adc_filter: snapshots four raw 10-bit ADC channels at a fixed rate
// and runs each through a shared first-order IIR low-pass (coefficient
// 1/2^Shift), with per-channel over-limit flags that use hysteresis.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the sample-rate tick
// CAPTURE | latch adc1..4 together into the snapshot registers
// CALC    | four cycles, one channel per cycle (ch = 0..3)
// DONE    | pulse sample_valid, mark filter as primed
module icewerx_adc_filter #(
    parameter int ClkFrequency = 12000000,
    parameter int SampleRate   = 1000,
    parameter int Shift        = 3,
    parameter int Hysteresis   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] adc1,
    input  logic [9:0] adc2,
    input  logic [9:0] adc3,
    input  logic [9:0] adc4,
    input  logic [9:0] limit,
    output logic [9:0] filt1,
    output logic [9:0] filt2,
    output logic [9:0] filt3,
    output logic [9:0] filt4,
    output logic [3:0] over,
    output logic       sample_valid
);

    localparam int              Div     = ClkFrequency / SampleRate;
    localparam int              CntW    = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
    localparam int              AccW    = 10 + Shift;
    localparam logic [10:0]     HystW   = 11'(Hysteresis);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CALC    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CntW-1:0] tick_cnt;
    logic            tick;
    logic [1:0]      ch;
    logic            primed;
    logic [9:0]      snap [4];
    logic [AccW-1:0] acc  [4];
    logic [9:0]      filt [4];
    logic [3:0]      over_q;

    logic [9:0]      x_cur;
    logic [AccW-1:0] acc_cur;
    logic [AccW-1:0] acc_new;
    logic [9:0]      filt_new;
    logic [10:0]     thr_set;
    logic            over_set;
    logic            over_clr;

    // Free-running sample-rate counter; tick marks its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CntLast) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CntW'(1);
        end
    end

    assign tick = (tick_cnt == CntLast);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and sample_valid decode; ticks outside IDLE are ignored.
    always_comb begin
        state_nxt    = state;
        sample_valid = 1'b0;
        case (state)
            IDLE:    if (tick) state_nxt = CAPTURE;
            CAPTURE: state_nxt = CALC;
            CALC:    if (ch == 2'd3) state_nxt = DONE;
            DONE: begin
                sample_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared IIR datapath for the channel selected by ch; the first pass
    // after reset preloads the accumulator so the output starts at the raw value.
    always_comb begin
        x_cur   = snap[ch];
        acc_cur = acc[ch];
        if (primed) begin
            // acc - (acc >> Shift) never goes negative and the sum stays
            // below 2^AccW, so AccW bits hold the full result.
            acc_new = acc_cur - (acc_cur >> Shift) + AccW'(x_cur);
        end else begin
            acc_new = AccW'(x_cur) << Shift;
        end
        filt_new = 10'(acc_new >> Shift);
        thr_set  = {1'b0, limit} + HystW;
        over_set = ({1'b0, filt_new} >= thr_set);
        over_clr = (filt_new < limit);
    end

    // Snapshot, accumulator, output and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch     <= 2'd0;
            primed <= 1'b0;
            over_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                snap[i] <= '0;
                acc[i]  <= '0;
                filt[i] <= '0;
            end
        end else begin
            case (state)
                CAPTURE: begin
                    snap[0] <= adc1;
                    snap[1] <= adc2;
                    snap[2] <= adc3;
                    snap[3] <= adc4;
                    ch      <= 2'd0;
                end
                CALC: begin
                    acc[ch]  <= acc_new;
                    filt[ch] <= filt_new;
                    if (over_set) begin
                        over_q[ch] <= 1'b1;
                    end else if (over_clr) begin
                        over_q[ch] <= 1'b0;
                    end
                    ch <= ch + 2'd1;
                end
                DONE: begin
                    primed <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign filt1 = filt[0];
    assign filt2 = filt[1];
    assign filt3 = filt[2];
    assign filt4 = filt[3];
    assign over  = over_q;

endmodule

// File: tb/tb_icewerx_adc_filter.sv
// Bench for icewerx_adc_filter. Two instances share clk/rst_n with a 10-cycle
// sample period: dut_a (Shift=3) exercises preload, step response, settling,
// capture timing and mid-pass reset; dut_b (Shift=0, so filt equals the raw
// input) exercises the hysteresis thresholds with a hand-written table.
// Expected results are queued when a pass is launched and checked by
// monitors on sample_valid.
module tb_icewerx_adc_filter;

    typedef struct packed {
        logic [9:0] f1;
        logic [9:0] f2;
        logic [9:0] f3;
        logic [9:0] f4;
        logic [3:0] ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] adc_a [4];
    logic [9:0] adc_b [4];
    logic [9:0] limit_a;
    logic [9:0] limit_b;
    logic [9:0] fa [4];
    logic [9:0] fb [4];
    logic [3:0] ov_a;
    logic [3:0] ov_b;
    logic       sv_a;
    logic       sv_b;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    exp_t q_a [$];
    exp_t q_b [$];
    exp_t e_a;
    exp_t e_b;

    // Reference state for dut_a.
    int         acc_m [4];
    logic [9:0] fa_m  [4];
    logic [3:0] ov_m;
    bit         primed_m;

    // dut_b channel-3 table: input, limit, expected over[2].
    int b_adc3 [5] = '{507, 508, 500, 499, 1023};
    int b_lim  [5] = '{500, 500, 500, 500, 1020};
    int b_ov3  [5] = '{0,   1,   1,   0,   0};
    int brow;

    icewerx_adc_filter #(
        .ClkFrequency(1000), .SampleRate(100), .Shift(3), .Hysteresis(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .adc1(adc_a[0]), .adc2(adc_a[1]), .adc3(adc_a[2]), .adc4(adc_a[3]),
        .limit(limit_a),
        .filt1(fa[0]), .filt2(fa[1]), .filt3(fa[2]), .filt4(fa[3]),
        .over(ov_a), .sample_valid(sv_a)
    );

    icewerx_adc_filter #(
        .ClkFrequency(1000), .SampleRate(100), .Shift(0), .Hysteresis(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .adc1(adc_b[0]), .adc2(adc_b[1]), .adc3(adc_b[2]), .adc4(adc_b[3]),
        .limit(limit_b),
        .filt1(fb[0]), .filt2(fb[1]), .filt3(fb[2]), .filt4(fb[3]),
        .over(ov_b), .sample_valid(sv_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor for dut_a: pulse width, pass period, and queued results.
    bit prev_sv_a = 1'b0;
    bit have_last = 1'b0;
    int last_sv   = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sv_a = 1'b0;
            have_last = 1'b0;
        end else begin
            if (prev_sv_a) chk("a_sv_width", int'(sv_a), 0);
            if (sv_a) begin
                if (have_last) chk("a_sv_period", cyc - last_sv, 10);
                have_last = 1'b1;
                last_sv   = cyc;
                if (q_a.size() == 0) begin
                    chk("a_unexpected_pass", 1, 0);
                end else begin
                    e_a = q_a.pop_front();
                    chk("a_filt1", int'(fa[0]), int'(e_a.f1));
                    chk("a_filt2", int'(fa[1]), int'(e_a.f2));
                    chk("a_filt3", int'(fa[2]), int'(e_a.f3));
                    chk("a_filt4", int'(fa[3]), int'(e_a.f4));
                    chk("a_over",  int'(ov_a),  int'(e_a.ov));
                end
            end
            prev_sv_a = sv_a;
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n && sv_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_pass", 1, 0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_filt1", int'(fb[0]), int'(e_b.f1));
                chk("b_filt2", int'(fb[1]), int'(e_b.f2));
                chk("b_filt3", int'(fb[2]), int'(e_b.f3));
                chk("b_filt4", int'(fb[3]), int'(e_b.f4));
                chk("b_over",  int'(ov_b),  int'(e_b.ov));
            end
        end
    end

    task automatic set_brow(input int r);
        brow     = r;
        adc_b[2] = 10'(b_adc3[r]);
        limit_b  = 10'(b_lim[r]);
    endtask

    // Queue the results the next pass must produce from the current inputs.
    task automatic push_pass();
        exp_t ea;
        exp_t eb;
        int   f;
        for (int i = 0; i < 4; i++) begin
            if (primed_m) acc_m[i] = acc_m[i] - (acc_m[i] >> 3) + int'(adc_a[i]);
            else          acc_m[i] = int'(adc_a[i]) * 8;
            f = acc_m[i] / 8;
            if (f >= int'(limit_a) + 8)  ov_m[i] = 1'b1;
            else if (f < int'(limit_a))  ov_m[i] = 1'b0;
            fa_m[i] = 10'(f);
        end
        primed_m = 1'b1;
        ea.f1 = fa_m[0];
        ea.f2 = fa_m[1];
        ea.f3 = fa_m[2];
        ea.f4 = fa_m[3];
        ea.ov = ov_m;
        eb.f1 = adc_b[0];
        eb.f2 = adc_b[1];
        eb.f3 = adc_b[2];
        eb.f4 = adc_b[3];
        eb.ov = (b_ov3[brow] != 0) ? 4'b0100 : 4'b0000;
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic wait_pass();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sv_a) seen = 1'b1;
        end
        if (!seen) chk("pass_timeout", 0, 1);
    endtask

    // late4 >= 0: change adc4 of dut_a in the cycle after CAPTURE
    // (only valid when called right after a previous pass's DONE).
    task automatic do_pass(input int late4);
        push_pass();
        if (late4 >= 0) begin
            repeat (6) @(posedge clk);
            #1 adc_a[3] = 10'(late4);
        end
        wait_pass();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_filt1"}, int'(fa[0]), 0);
        chk({tag, "_filt2"}, int'(fa[1]), 0);
        chk({tag, "_filt3"}, int'(fa[2]), 0);
        chk({tag, "_filt4"}, int'(fa[3]), 0);
        chk({tag, "_over"},  int'(ov_a),  0);
        chk({tag, "_sv"},    int'(sv_a),  0);
        chk({tag, "_b_filt3"}, int'(fb[2]), 0);
    endtask

    initial begin
        rst_n    = 1'b1;
        adc_a    = '{10'd512, 10'd0, 10'd1023, 10'd300};
        adc_b    = '{10'd0, 10'd0, 10'd0, 10'd0};
        limit_a  = 10'd900;
        primed_m = 1'b0;
        ov_m     = 4'd0;
        for (int i = 0; i < 4; i++) acc_m[i] = 0;
        set_brow(0);

        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Preload on the first pass: 512, 0, 1023, 300.
        do_pass(-1);

        // Step ch2 0 -> 1000 (125, 234, ...), ch4 300 -> 777; dut_b walks
        // 507, 508, 500, 499 around limit 500, then 1023 with limit 1020.
        adc_a[1] = 10'd1000;
        adc_a[3] = 10'd777;
        for (int p = 0; p < 80; p++) begin
            set_brow((p + 1 < 4) ? p + 1 : 4);
            do_pass(-1);
        end
        chk("a_ch2_settled", int'(fa[1]), 1000);
        chk("a_ch4_settled", int'(fa[3]), 777);

        // adc4 changed after CAPTURE: this pass still sees 777, the next sees 100.
        do_pass(100);
        chk("a_late_change_ignored", int'(fa[3]), 777);
        do_pass(-1);

        // Reset during CALC ch=1: outputs clear at once, next pass preloads.
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        primed_m = 1'b0;
        ov_m     = 4'd0;
        for (int i = 0; i < 4; i++) acc_m[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_pass(-1);
        chk("a_repreload_ch2", int'(fa[1]), 1000);
        chk("a_repreload_ch4", int'(fa[3]), 100);
        do_pass(-1);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
